// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for a synchronous FIFO with a registered 1-cycle
//   read latency. A start pulse in IDLE launches a burst of exactly `len`
//   words, which are read from the FIFO and presented on a valid/ready
//   stream. A 2-entry output buffer absorbs the read latency, so the block
//   sustains one word per cycle and never drops or repeats a word when the
//   consumer applies backpressure.
//
// Ports
//   clk        : system clock, rising edge
//   clr        : asynchronous active-high reset
//   start      : one-cycle burst request, only honoured in IDLE
//   len        : burst length in words, captured with start
//   busy       : high while the burst is running or draining
//   done       : one-cycle pulse when a burst completes
//   fifo_empty : FIFO empty flag
//   fifo_r_en  : FIFO read enable (never asserted while fifo_empty=1)
//   fifo_data  : FIFO read data, valid the cycle after fifo_r_en
//   m_valid    : output word valid
//   m_ready    : consumer ready
//   m_data     : output word (head of the output buffer)

module fifo_burst_reader #(
  parameter int data_width = 8,
  parameter int len_width  = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [len_width-1:0]  len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [data_width-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [len_width-1:0] c_len_one = {{(len_width-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;

  logic [len_width-1:0]  r_len;
  logic [len_width-1:0]  r_issued;
  logic [len_width-1:0]  r_delivered;
  logic [len_width-1:0]  w_delivered_next;

  // Output buffer: two entries addressed by 1-bit wrapping pointers.
  logic [data_width-1:0] r_buf [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic [1:0]            w_occ_next;

  // A read was issued last cycle; its data is on fifo_data this cycle.
  logic                  r_pend;

  logic                  w_pop;
  logic                  w_r_en;
  logic [2:0]            w_fill;
  logic                  w_start_acc;

  // ------------------------------------------------------------------
  // Stream side
  // ------------------------------------------------------------------
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf[r_rd_ptr];
  assign w_pop   = m_valid && m_ready;

  // Projected occupancy at the next edge if another read were issued now:
  // words held, plus the word in flight, minus the word leaving. Keeping
  // this below 2 guarantees the buffer can never be overrun.
  assign w_fill = {1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop};

  assign w_r_en = (r_state == ST_RUN) && !fifo_empty &&
                  (r_issued < r_len) && (w_fill < 3'd2);

  assign fifo_r_en = w_r_en;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);

  assign w_start_acc      = (r_state == ST_IDLE) && start;
  assign w_delivered_next = r_delivered + {{(len_width-1){1'b0}}, w_pop};
  assign w_occ_next       = r_occ + {1'b0, r_pend} - {1'b0, w_pop};

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_issued == r_len) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Look at the handshake happening now so done lands on the cycle
        // right after the final transfer.
        if (w_delivered_next == r_len) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Burst counters
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
    end else if (w_start_acc) begin
      r_len       <= len;
      r_issued    <= '0;
      r_delivered <= '0;
    end else begin
      if (w_r_en) begin
        r_issued <= r_issued + c_len_one;
      end
      if (w_pop) begin
        r_delivered <= w_delivered_next;
      end
    end
  end

  // ------------------------------------------------------------------
  // Buffer pointers and occupancy
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pend   <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      r_pend <= w_r_en;
      if (r_pend) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Capture and pop in the same cycle leave occupancy unchanged; the
      // independent pointers keep the order intact.
      r_occ <= w_occ_next;
    end
  end

  // ------------------------------------------------------------------
  // Buffer storage
  // ------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
          r_buf[gi] <= '0;
        end else if (r_pend && (r_wr_ptr == 1'(gi))) begin
          r_buf[gi] <= fifo_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural FIFO with registered read
// feeds the DUT; expected words are queued when bursts are launched and
// compared as the DUT hands them off.

module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       fifo_empty;
  logic       fifo_r_en;
  logic [7:0] fifo_data = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  fifo_burst_reader #(
    .data_width(8),
    .len_width (8)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .fifo_empty(fifo_empty),
    .fifo_r_en (fifo_r_en),
    .fifo_data (fifo_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO: data appears on fifo_data the cycle after a read.
  logic [7:0] fifo_mem [0:255];
  int         fifo_wr = 0;
  int         fifo_rd = 0;
  assign fifo_empty = (fifo_wr == fifo_rd);

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data <= fifo_mem[fifo_rd[7:0]];
      fifo_rd   <= fifo_rd + 1;
    end
  end

  logic [7:0] exp_q [$];

  task automatic push_word(input logic [7:0] w, input bit expect_out);
    fifo_mem[fifo_wr[7:0]] = w;
    fifo_wr = fifo_wr + 1;
    if (expect_out) exp_q.push_back(w);
  endtask

  // Monitor / scoreboard
  int         cyc = 0;
  int         ren_cnt = 0;
  int         hs_cnt = 0;
  int         last_hs_cyc = -10;
  bit         chk_done_lat = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic [7:0] exp_w;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!clr) begin
      if (fifo_r_en) begin
        ren_cnt++;
        check_val("ren_while_empty", 32'(fifo_empty), 32'd0);
      end
      if (stall_prev) begin
        check_val("hold_valid", 32'(m_valid), 32'd1);
        check_val("hold_data", 32'(m_data), 32'(data_prev));
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        check_val("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check_val("sb_data", 32'(m_data), 32'(exp_w));
          $display("xfer cyc=%0d data=0x%02h exp=0x%02h", cyc, m_data, exp_w);
        end
      end
      if (done && chk_done_lat) begin
        check_val("done_after_last_hs", 32'(cyc), 32'(last_hs_cyc + 1));
      end
      stall_prev = m_valid && !m_ready;
      data_prev  = m_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [7:0] n);
    len          = n;
    start        = 1'b1;
    chk_done_lat = (n != 8'd0);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_r_en"}, 32'(fifo_r_en), 32'd0);
    check_val({tag, "_m_data"}, 32'(m_data), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int r0;
  int h0;
  int hs_wait;

  initial begin
    clr     = 1'b0;
    start   = 1'b0;
    len     = 8'd0;
    m_ready = 1'b0;

    // 1: asynchronous clear, no clock edge yet
    #2 clr = 1'b1;
    #1 check_reset_outputs("t1");
    $display("t1 async clear checked");
    tick();
    clr = 1'b0;
    tick();

    // 2: four words, consumer always ready
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    m_ready = 1'b1;
    r0 = ren_cnt;
    start_burst(8'd4);
    check_val("t2_c1_ren", 32'(fifo_r_en), 32'd1);
    check_val("t2_c1_busy", 32'(busy), 32'd1);
    tick();
    check_val("t2_c2_ren", 32'(fifo_r_en), 32'd1);
    check_val("t2_c2_valid", 32'(m_valid), 32'd0);
    tick();
    check_val("t2_c3_ren", 32'(fifo_r_en), 32'd1);
    check_val("t2_c3_valid", 32'(m_valid), 32'd1);
    check_val("t2_c3_data", 32'(m_data), 32'h11);
    tick();
    check_val("t2_c4_ren", 32'(fifo_r_en), 32'd1);
    check_val("t2_c4_data", 32'(m_data), 32'h22);
    tick();
    check_val("t2_c5_ren", 32'(fifo_r_en), 32'd0);
    check_val("t2_c5_data", 32'(m_data), 32'h33);
    tick();
    check_val("t2_c6_data", 32'(m_data), 32'h44);
    check_val("t2_c6_done", 32'(done), 32'd0);
    tick();
    check_val("t2_c7_done", 32'(done), 32'd1);
    check_val("t2_c7_busy", 32'(busy), 32'd0);
    tick();
    check_val("t2_c8_done", 32'(done), 32'd0);
    check_val("t2_ren_total", 32'(ren_cnt - r0), 32'd4);
    $display("t2 burst len=4 ready=1 reads=%0d", ren_cnt - r0);

    // 3: consumer stalled, then released
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b1);
    push_word(8'h44, 1'b1);
    m_ready = 1'b0;
    r0 = ren_cnt;
    start_burst(8'd4);
    repeat (8) tick();
    check_val("t3_stall_reads", 32'(ren_cnt - r0), 32'd2);
    check_val("t3_stall_valid", 32'(m_valid), 32'd1);
    check_val("t3_stall_data", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    wait_done("t3_done_seen", 40);
    check_val("t3_ren_total", 32'(ren_cnt - r0), 32'd4);
    $display("t3 burst len=4 stalled reads=%0d", ren_cnt - r0);
    tick();

    // 4: FIFO underflow mid-burst, start ignored while busy
    push_word(8'hA5, 1'b1);
    r0 = ren_cnt;
    h0 = hs_cnt;
    start_burst(8'd3);
    len   = 8'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check_val("t4_partial_reads", 32'(ren_cnt - r0), 32'd1);
    check_val("t4_partial_xfers", 32'(hs_cnt - h0), 32'd1);
    check_val("t4_busy", 32'(busy), 32'd1);
    push_word(8'hB6, 1'b1);
    push_word(8'hC7, 1'b1);
    wait_done("t4_done_seen", 40);
    check_val("t4_ren_total", 32'(ren_cnt - r0), 32'd3);
    $display("t4 burst len=3 underflow reads=%0d", ren_cnt - r0);
    tick();

    // 5: zero-length burst, start during DONE ignored
    r0 = ren_cnt;
    start_burst(8'd0);
    check_val("t5_done", 32'(done), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_ren", 32'(fifo_r_en), 32'd0);
    check_val("t5_valid", 32'(m_valid), 32'd0);
    len   = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("t5_idle_done", 32'(done), 32'd0);
    check_val("t5_idle_busy", 32'(busy), 32'd0);
    tick();
    check_val("t5_ignored_busy", 32'(busy), 32'd0);
    check_val("t5_ignored_reads", 32'(ren_cnt - r0), 32'd0);
    $display("t5 burst len=0 reads=%0d", ren_cnt - r0);

    // 6: clear mid-burst after two words, then a fresh burst
    push_word(8'h11, 1'b1);
    push_word(8'h22, 1'b1);
    push_word(8'h33, 1'b0);
    h0 = hs_cnt;
    start_burst(8'd4);
    hs_wait = 0;
    while ((hs_cnt - h0) < 2 && hs_wait < 20) begin
      tick();
      hs_wait++;
    end
    check_val("t6_two_xfers", 32'(hs_cnt - h0), 32'd2);
    check_val("t6_pre_clr_valid", 32'(m_valid), 32'd1);
    clr = 1'b1;
    #1 check_reset_outputs("t6_clr");
    tick();
    clr = 1'b0;
    tick();
    check_val("t6_idle_busy", 32'(busy), 32'd0);
    push_word(8'h44, 1'b1);
    push_word(8'h55, 1'b1);
    start_burst(8'd2);
    wait_done("t6_done_seen", 40);
    $display("t6 clear mid-burst then len=2");
    tick();

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
